// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with exact bit-period sampling, feeding a first-word-fall-through FIFO.
// Sticky overrun/frame_err flags are cleared by clear_err; a same-cycle set event takes priority.
module uart_rx_fifo #(
  parameter int DIVIDER = 25000000 / 115200,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       full,
  output logic       overrun,
  output logic       frame_err,
  input  logic       clear_err
);

  localparam int CW   = $clog2(DIVIDER + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int HALF = DIVIDER / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_idx;
  logic [7:0]     r_shift;
  logic           r_sync1;
  logic           r_sync2;
  logic           r_overrun;
  logic           r_frame_err;

  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;

  logic           w_line;
  logic           w_stop_smp;
  logic           w_push;
  logic           w_ferr;
  logic           w_full;
  logic           w_pop;
  logic           w_push_ok;
  logic           w_drop;

  // Two-stage synchronizer; both stages idle high so reset never fakes a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line     = r_sync2;
  assign w_stop_smp = (r_state == S_STOP) && (r_cnt == CW'(DIVIDER));
  assign w_push     = w_stop_smp && w_line;
  assign w_ferr     = w_stop_smp && !w_line;

  // r_cnt holds cycles elapsed since the last sample point, so every period is exact
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_line) begin
            r_state <= S_START;
            r_cnt   <= CW'(1);
          end
        end
        S_START: begin
          if (r_cnt == CW'(HALF)) begin
            if (!w_line) begin
              r_state <= S_DATA;
              r_cnt   <= CW'(1);
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == CW'(DIVIDER)) begin
            r_shift[r_idx] <= w_line;
            r_cnt          <= CW'(1);
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_stop_smp) begin
            r_cnt   <= '0;
            r_state <= w_line ? S_IDLE : S_BREAK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_line) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = (r_count != '0) && ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // Storage carries no reset; data is masked to zero while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_err) begin
        r_overrun <= 1'b0;
      end
      if (w_ferr) begin
        r_frame_err <= 1'b1;
      end else if (clear_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign valid     = (r_count != '0);
  assign data      = valid ? r_mem[r_rptr] : 8'h00;
  assign full      = w_full;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIVIDER=4, DEPTH=4: framing, FIFO order, overrun,
// glitch rejection, break handling, simultaneous push/pop when full, and mid-frame reset.
module tb_uart_rx_fifo;

  localparam int DIV = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       full;
  logic       overrun;
  logic       frame_err;
  logic       clear_err;

  int nvec  = 0;
  int nfail = 0;

  uart_rx_fifo #(.DIVIDER(DIV), .DEPTH(DEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .serial    (serial),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .full      (full),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, then the stop bit; a nonzero stop_low holds
  // the stop bit low for that many cycles. Returns 1 ns after edge E39 (stop sample at E40).
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    serial = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      idle(DIV);
    end
    if (stop_low == 0) begin
      serial = 1'b1;
      idle(DIV);
    end else begin
      serial = 1'b0;
      idle(stop_low);
      serial = 1'b1;
    end
  endtask

  task automatic pop_one;
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    serial    = 1'b1;
    ready     = 1'b0;
    clear_err = 1'b0;
    idle(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    idle(4);

    // Single frame, exact latency
    send_frame(8'h5A, 0);
    chk("5a_valid_before", valid, 0);
    idle(1);
    chk("5a_valid", valid, 1);
    chk("5a_data", data, 8'h5A);
    chk("5a_overrun", overrun, 0);
    chk("5a_frame_err", frame_err, 0);
    pop_one();
    chk("5a_popped", valid, 0);
    idle(3);

    // Five frames into a 4-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 0);
      idle(2);
      if (k == 4) begin
        chk("fill_full4", full, 1);
        chk("fill_ovr4", overrun, 0);
      end
    end
    chk("fill_full5", full, 1);
    chk("fill_ovr5", overrun, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("fill_pop_data", data, 32'(k));
      pop_one();
    end
    chk("fill_empty", valid, 0);
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // One-cycle glitch is rejected, next frame is clean
    serial = 1'b0;
    idle(1);
    serial = 1'b1;
    idle(12);
    chk("glitch_nopush", valid, 0);
    send_frame(8'hC3, 0);
    idle(2);
    chk("c3_valid", valid, 1);
    chk("c3_data", data, 8'hC3);
    pop_one();

    // Stop bit low for 3 bit periods: framing error, no push, then recovery
    idle(3);
    send_frame(8'hFF, 3 * DIV);
    chk("brk_frame_err", frame_err, 1);
    chk("brk_nopush", valid, 0);
    idle(6);
    send_frame(8'h12, 0);
    idle(2);
    chk("brk_12_data", data, 8'h12);
    chk("brk_12_valid", valid, 1);
    chk("brk_err_sticky", frame_err, 1);
    pop_one();
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    chk("ferr_cleared", frame_err, 0);

    // Full FIFO with push and pop on the same edge
    idle(3);
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h10 + 8'(k), 0);
      idle(2);
    end
    chk("pp_full_before", full, 1);
    send_frame(8'h14, 0);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    chk("pp_full_after", full, 1);
    chk("pp_overrun", overrun, 0);
    chk("pp_head", data, 8'h11);
    for (int k = 1; k <= 4; k++) begin
      chk("pp_order", data, 32'h10 + 32'(k));
      pop_one();
    end
    chk("pp_empty", valid, 0);

    // Reset mid-frame discards the partial byte and the queued one
    idle(3);
    send_frame(8'h77, 0);
    idle(2);
    chk("mid_pre_valid", valid, 1);
    serial = 1'b0;
    idle(DIV);
    for (int i = 0; i < 3; i++) begin
      serial = (8'hAA >> i) & 8'h01;
      idle(DIV);
    end
    reset  = 1'b1;
    serial = 1'b1;
    idle(1);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_data", data, 8'h00);
    idle(3);
    reset = 1'b0;
    idle(6);
    chk("mid_after_valid", valid, 0);
    send_frame(8'h3C, 0);
    idle(2);
    chk("mid_3c_data", data, 8'h3C);
    pop_one();
    chk("mid_only_3c", valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DIVIDER, default 25000000/115200 (217), clock cycles per bit; legal range is DIVIDER >= 4.
REQ-002 Parameter: DEPTH, default 8, FIFO entries; the value SHALL be a power of two >= 2.
REQ-003 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: serial  in  1  asynchronous UART line (8N1, LSB first), idles high.
REQ-006 Port: data  out  8  head-of-FIFO byte; valid only while valid=1.
REQ-007 Port: valid  out  1  FIFO non-empty.
REQ-008 Port: ready  in  1  consumer accepts head byte; pop = valid & ready.
REQ-009 Port: full  out  1  FIFO holds DEPTH bytes.
REQ-010 Port: overrun  out  1  sticky: a received byte was dropped because the FIFO was full.
REQ-011 Port: frame_err  out  1  sticky: a stop bit was sampled low.
REQ-012 Port: clear_err  in  1  clears overrun and frame_err.

Function
REQ-013 serial SHALL pass through a 2-FF synchronizer (both stages reset to 1); "line" below means the synchronizer output.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA, STOP and BREAK, plus a bit-period counter and a 3-bit bit index.
REQ-015 IDLE: when line=0 in cycle t, the FSM SHALL go to START and the start bit SHALL be sampled at t+DIVIDER/2 (integer division).
REQ-016 START sample: if line=0, go to DATA; if line=1, treat it as a glitch, return to IDLE, and push nothing.
REQ-017 DATA: bit i (i=0..7) SHALL be sampled at t+DIVIDER/2+(i+1)*DIVIDER into shift-register bit i; after bit 7, go to STOP.
REQ-018 STOP: sample at t+DIVIDER/2+9*DIVIDER.
- line=1: push the byte and go to IDLE.
- line=0: discard the byte, set frame_err, and go to BREAK.
REQ-019 BREAK: remain until line=1, then go to IDLE; no start detection occurs while in BREAK.
REQ-020 The FIFO SHALL be first-word-fall-through.
- data = entry at the read pointer; valid = (count != 0).
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
REQ-021 Latency: a pushed byte SHALL appear with valid=1 on the cycle after the stop-bit sample cycle.
REQ-022 Push when full and no pop in the same cycle: drop the byte and set overrun; FIFO contents are unchanged.
REQ-023 Push and pop in the same cycle: both SHALL take effect (including when full) and count SHALL be unchanged.
REQ-024 Pop when empty: no effect, since valid=0 means no pop occurs.
REQ-025 When clear_err=1, overrun and frame_err SHALL be 0 next cycle.
- If a set event coincides with clear_err=1, the set event wins.
REQ-026 full = (count == DEPTH); data and valid SHALL be driven from registered state only.
REQ-027 Bit-period timing SHALL be exact; no cumulative drift is permitted across the 10 samples.

Reset
REQ-028 reset=1 SHALL force all of the following on the next clock edge:
- FSM = IDLE, counters = 0, synchronizer = 1;
- FIFO pointers and count = 0;
- overrun = 0, frame_err = 0, valid = 0, full = 0.
REQ-029 Reset asserted mid-frame SHALL abandon the partial byte. After release, reception SHALL restart only on a new falling edge of line.
REQ-030 data SHALL read 8'h00 out of reset.

Verification (DIVIDER=4, DEPTH=4 unless noted)
REQ-031 Send frame 0x5A with ready=0 -> valid=1 and data=0x5A one cycle after the stop sample; flags remain 0.
REQ-032 Send 5 frames 0x01..0x05 with ready=0 -> full=1 after the 4th frame, overrun=1 after the 5th; popping yields 0x01..0x04 in order.
REQ-033 Low pulse of 1 cycle (shorter than DIVIDER/2) on serial -> FSM back in IDLE and no push; a following valid frame 0xC3 is received correctly.
REQ-034 Frame 0xFF sent with its stop bit held low for 3*DIVIDER -> frame_err=1, no push, FSM in BREAK until line is high; then 0x12 is received; clear_err -> frame_err=0.
REQ-035 FIFO full, with a stop-bit push and ready=1 in the same cycle -> count stays 4, overrun=0, new byte at the tail, old head popped.
REQ-036 Assert reset during DATA of frame 0xAA, release, then send 0x3C -> only 0x3C appears; valid=0 while reset is asserted.
